// File: rtl/lsb_embed_ctrl.sv
// lsb_embed_ctrl: hides a byte stream in bit 0 of successive pixels.
// MSB-first per byte, row-major pixel order, one bit per pixel.
module lsb_embed_ctrl #(
  parameter int image_size = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*image_size-3:0] msg_len,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic [image_size-1:0]   img_row,
  output logic [image_size-1:0]   img_col,
  output logic                    img_we,
  output logic [23:0]             img_in,
  input  logic [23:0]             img_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LW = 2*image_size-2;
  localparam int AW = 2*image_size;

  // Capacity in bytes: one bit per pixel, 2^(2*image_size-3).
  localparam logic [LW-1:0] CAP = {1'b1, {(LW-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_EMBED = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [LW-1:0] r_rem;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bit;
  logic [AW-1:0] r_addr;
  logic          r_err;
  logic          w_we;

  // Row-major address: the column is the low half, so a column wrap
  // carries into the row.
  assign img_row = r_addr[AW-1:image_size];
  assign img_col = r_addr[image_size-1:0];

  // Write drops in the same cycle reset is asserted.
  assign w_we       = (r_state == S_EMBED) && rst_n;
  assign img_we     = w_we;
  assign img_in     = w_we ? {img_out[23:1], r_shreg[7]} : 24'd0;
  assign byte_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;

  // Sequencer: capacity check, byte intake, 8 write cycles per byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_shreg <= '0;
      r_bit   <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem  <= msg_len;
            r_err  <= 1'b0;
            r_addr <= '0;
            if (msg_len == '0) begin
              r_state <= S_DONE;
            end else if (msg_len > CAP) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            r_shreg <= byte_data;
            r_rem   <= r_rem - 1'b1;
            r_bit   <= '0;
            r_state <= S_EMBED;
          end
        end
        S_EMBED: begin
          r_shreg <= r_shreg << 1;
          r_addr  <= r_addr + 1'b1;
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            r_state <= (r_rem != '0) ? S_LOAD : S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_embed_ctrl.sv
// tb_lsb_embed_ctrl: directed bench for lsb_embed_ctrl, image_size=2.
// A 4x4 pixel memory model sits on the image port.
module tb_lsb_embed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  msg_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [1:0]  img_row;
  logic [1:0]  img_col;
  logic        img_we;
  logic [23:0] img_in;
  logic [23:0] img_out;
  logic        busy;
  logic        done;
  logic        err;

  logic [23:0] mem [0:3][0:3];
  logic        do_init;
  int          wr_cnt;
  logic [1:0]  last_row;
  logic [1:0]  last_col;

  int n_err = 0;
  int n_chk = 0;

  lsb_embed_ctrl #(.image_size(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .msg_len    (msg_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .img_row    (img_row),
    .img_col    (img_col),
    .img_we     (img_we),
    .img_in     (img_in),
    .img_out    (img_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign img_out = mem[img_row][img_col];

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          mem[i][j] <= 24'(i + j);
      wr_cnt <= 0;
    end else if (img_we) begin
      mem[img_row][img_col] <= img_in;
      wr_cnt   <= wr_cnt + 1;
      last_row <= img_row;
      last_col <= img_col;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem;
    do_init = 1'b1;
    tick();
    do_init = 1'b0;
  endtask

  task automatic start_msg(input logic [1:0] len);
    start   = 1'b1;
    msg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".ready"}, 32'(byte_ready), 0);
    chk({tag, ".we"},    32'(img_we),     0);
    chk({tag, ".row"},   32'(img_row),    0);
    chk({tag, ".col"},   32'(img_col),    0);
    chk({tag, ".in"},    32'(img_in),     0);
    chk({tag, ".busy"},  32'(busy),       0);
    chk({tag, ".done"},  32'(done),       0);
    chk({tag, ".err"},   32'(err),        0);
  endtask

  logic [23:0] exp_a5 [8];
  logic [23:0] exp_3c [8];
  int          cyc;
  logic [23:0] ev;

  initial begin
    exp_a5 = '{24'd1, 24'd0, 24'd3, 24'd2, 24'd0, 24'd3, 24'd2, 24'd5};
    exp_3c = '{24'd0, 24'd0, 24'd3, 24'd3, 24'd1, 24'd3, 24'd2, 24'd4};
    rst_n      = 1'b0;
    start      = 1'b0;
    msg_len    = 2'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    do_init    = 1'b0;
    init_mem();
    tick();
    chk_idle_outs("reset");
    rst_n = 1'b1;
    tick();

    // One byte 0xA5, valid held high.
    init_mem();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    start_msg(2'd1);
    chk("t1.busy",  32'(busy),       1);
    chk("t1.ready", 32'(byte_ready), 1);
    wait_done(1, cyc);
    chk("t1.done_cyc", cyc, 10);
    byte_valid = 1'b0;
    tick();
    chk("t1.done_pulse", 32'(done), 0);
    chk("t1.busy_end",   32'(busy), 0);
    chk("t1.writes",     wr_cnt,    8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t1.px%0d", k), 32'(mem[k/4][k%4]), 32'(exp_a5[k]));
    for (int k = 8; k < 16; k++)
      chk($sformatf("t1.untouched%0d", k), 32'(mem[k/4][k%4]),
          32'(k/4 + k%4));

    // Two bytes 0xFF, 0x00 back to back: full capacity.
    init_mem();
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    start_msg(2'd2);
    tick();
    byte_data = 8'h00;
    wait_done(2, cyc);
    chk("t2.done_cyc", cyc, 19);
    byte_valid = 1'b0;
    tick();
    chk("t2.writes",   wr_cnt,          16);
    chk("t2.last_row", 32'(last_row),   3);
    chk("t2.last_col", 32'(last_col),   3);
    for (int k = 0; k < 16; k++) begin
      ev = 24'(k/4 + k%4);
      ev[0] = (k < 8);
      chk($sformatf("t2.px%0d", k), 32'(mem[k/4][k%4]), 32'(ev));
    end

    // Overflow: msg_len=3 exceeds capacity of 2.
    init_mem();
    start_msg(2'd3);
    chk("t3.err",  32'(err),  1);
    chk("t3.busy", 32'(busy), 0);
    tick();
    tick();
    chk("t3.err_sticky", 32'(err),  1);
    chk("t3.busy_idle",  32'(busy), 0);
    chk("t3.writes",     wr_cnt,    0);

    // Legal start clears err; byte_valid low 5 cycles in LOAD.
    start_msg(2'd1);
    chk("t4.err_clr", 32'(err), 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4.ready%0d", k), 32'(byte_ready), 1);
      chk($sformatf("t4.we%0d", k),    32'(img_we),     0);
      chk($sformatf("t4.addr%0d", k),  32'({img_row, img_col}), 0);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = 8'h3C;
    wait_done(6, cyc);
    chk("t4.done_cyc", cyc, 15);
    byte_valid = 1'b0;
    tick();
    chk("t4.writes", wr_cnt, 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4.px%0d", k), 32'(mem[k/4][k%4]), 32'(exp_3c[k]));

    // Reset during the 4th write cycle.
    init_mem();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    start_msg(2'd1);
    tick();
    chk("t5.we1", 32'(img_we), 1);
    tick();
    tick();
    tick();
    chk("t5.we4", 32'(img_we), 1);
    rst_n = 1'b0;
    #1;
    chk("t5.we_rst", 32'(img_we), 0);
    chk("t5.in_rst", 32'(img_in), 0);
    tick();
    byte_valid = 1'b0;
    chk_idle_outs("t5.post");
    rst_n = 1'b1;
    tick();
    chk("t5.writes", wr_cnt, 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t5.px%0d", k), 32'(mem[k/4][k%4]), 32'(exp_a5[k]));
    for (int k = 3; k < 16; k++)
      chk($sformatf("t5.untouched%0d", k), 32'(mem[k/4][k%4]),
          32'(k/4 + k%4));

    // Start while busy is ignored; zero-length start completes at once.
    init_mem();
    start_msg(2'd1);
    start_msg(2'd0);
    chk("t6.busy",  32'(busy),       1);
    chk("t6.ready", 32'(byte_ready), 1);
    chk("t6.done",  32'(done),       0);
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    wait_done(2, cyc);
    chk("t6.done_cyc", cyc, 11);
    byte_valid = 1'b0;
    tick();
    chk("t6.writes", wr_cnt, 8);
    init_mem();
    start_msg(2'd0);
    chk("t6.z_done", 32'(done), 1);
    chk("t6.z_busy", 32'(busy), 1);
    tick();
    chk("t6.z_done_end", 32'(done), 0);
    chk("t6.z_busy_end", 32'(busy), 0);
    chk("t6.z_writes",   wr_cnt,    0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsb_embed_ctrl.md
# lsb_embed_ctrl

Sequencer that hides a byte stream in an image buffer by overwriting bit 0 of successive 24-bit pixels, one message bit per pixel. Bits go MSB-first, pixels row-major. It accepts message bytes over a valid/ready handshake and drives the row/col/we/in/out port of the image memory directly. It also owns address generation, capacity checking and completion signalling for the steganography flow.

## Interface

- image_size, default 6: log2 of image side; the image is 2^image_size x 2^image_size pixels.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin embedding; sampled only in IDLE.
- msg_len  in  2*image_size-2  message length in bytes, sampled with start.
- byte_valid  in  1  message byte available.
- byte_data  in  8  message byte.
- byte_ready  out  1  controller accepts byte_data this cycle.
- img_row  out  image_size  image row select.
- img_col  out  image_size  image column select.
- img_we  out  1  image write enable.
- img_in  out  24  pixel value written.
- img_out  in  24  pixel value read; combinational from img_row/img_col.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky capacity-overflow flag; cleared by the next accepted start.

## Operation

- Capacity: C = 2^(2*image_size-3) bytes, equal to one bit per pixel.
- States: IDLE, LOAD, EMBED, DONE.
- IDLE: waits for start.
  - On start, the controller latches msg_len into the remaining-byte counter, clears err and resets the pixel address to (0,0).
  - If msg_len == 0, go to DONE.
  - If msg_len > C, set err and stay in IDLE. No writes occur.
  - Otherwise go to LOAD.
- LOAD: byte_ready=1.
  - On byte_valid & byte_ready, the controller latches byte_data into an 8-bit shift register, decrements the remaining-byte counter and goes to EMBED.
  - With no valid byte it waits indefinitely.
- EMBED: 8 cycles, counted by a 3-bit bit counter.
  - Every cycle: img_we=1 and img_in = {img_out[23:1], shreg[7]}.
  - After each write the shift register shifts left and the address advances: col+1, and on col wrap to 0, row+1.
  - After the 8th bit: go to LOAD if the remaining count is nonzero, else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy.
- Bits 23:1 of every touched pixel must be unchanged. Untouched pixels are never written.
- img_in = 0 whenever img_we=0.
- Address wrap: the capacity check guarantees row never wraps past 2^image_size-1 during a legal message. When C bytes are embedded, the final pixel written is (2^image_size-1, 2^image_size-1).

## Timing

- Reset values:
  - state IDLE; byte_ready=0, img_we=0, img_row=0, img_col=0, img_in=0, busy=0, done=0, err=0.
  - Counters and shift register are 0.
- Reset mid-operation returns to IDLE the next edge. img_we drops immediately in the reset cycle. Partially embedded pixels keep their new LSBs.
- Latencies:
  - start to byte_ready: 1 cycle.
  - Byte handshake to first img_we: 1 cycle.
  - Per byte: 8 write cycles plus at least 1 LOAD cycle, so 9 cycles per byte minimum with byte_valid held high.
  - Last write to done: 1 cycle. Legal msg_len = N gives done at cycle 1+9N after start.
- start with msg_len=0 gives done 1 cycle after start.
- start with overflow: err rises the cycle after start; busy stays 0.
- byte_valid may deassert at any time outside the handshake cycle without effect.

## Test plan

- image_size=2 (C=2), image init data[i][j]=i+j, start with msg_len=1, byte 0xA5:
  - pixels (0,0)..(1,3) end with LSBs 1,0,1,0,0,1,0,1;
  - bits 23:1 equal the original values;
  - (2,0)..(3,3) unchanged;
  - done at cycle 10 after start.
- msg_len=2, bytes 0xFF then 0x00 with byte_valid held high:
  - all 16 pixels written, LSBs 1 for row 0–1 and 0 for row 2–3;
  - last write at (3,3); done at cycle 19.
- msg_len=3 (greater than C=2):
  - err=1 from the cycle after start, busy=0, img_we never asserted;
  - a following legal start clears err.
- byte_valid held low for 5 cycles in LOAD:
  - byte_ready stays 1, img_we stays 0, address unchanged;
  - embedding resumes correctly on the handshake.
- rst_n=0 during the 4th EMBED cycle:
  - img_we=0 that cycle and all outputs at reset values next cycle;
  - pixels (0,0)..(0,2) hold new LSBs, the rest are untouched.
- start pulsed while busy and msg_len=0 start:
  - the busy start has no effect;
  - the zero-length start gives done one cycle later with no writes.
